// File: rtl/spio_link_speed_doubler_pkg.sv
// rtl/spio_link_speed_doubler_pkg.sv - buffer depth and occupancy helpers for the link speed doubler
//
// Configuration macro: SPIO_LINK_SPEED_DOUBLER_SKID_EN
//   defined   -> DEPTH = 2 (output register + skid entry)
//   undefined -> DEPTH = 1 (output register only)

package spio_link_speed_doubler_pkg;

`ifdef SPIO_LINK_SPEED_DOUBLER_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    // Occupancy ranges 0..DEPTH, so two bits cover both builds.
    localparam int OCC_BITS = 2;

    typedef logic [OCC_BITS-1:0] occ_t;

    localparam occ_t DEPTH_OCC = occ_t'(DEPTH);

    function automatic occ_t occ_count(input logic out_vld, input logic skid_vld);
        return occ_t'(out_vld) + occ_t'(skid_vld);
    endfunction

endpackage

// File: rtl/spio_sclk_edge_detect.sv
// rtl/spio_sclk_edge_detect.sv - recovers SCLK phase in the FCLK domain
//
// Ports:
//   SCLK_IN   in   slow clock (half of FCLK_IN, rising edges aligned)
//   FCLK_IN   in   fast clock
//   RESET_IN  in   asynchronous, active-high reset
//   EDGE_OUT  out  high in the FCLK cycle whose closing edge is also an SCLK rising edge

module spio_sclk_edge_detect (
    input  logic SCLK_IN,
    input  logic FCLK_IN,
    input  logic RESET_IN,
    output logic EDGE_OUT
);

    logic toggle_s;
    logic started_s;
    logic toggle_f;

    always_ff @(posedge SCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            toggle_s  <= 1'b0;
            started_s <= 1'b0;
        end else begin
            toggle_s  <= ~toggle_s;
            started_s <= 1'b1;
        end
    end

    always_ff @(posedge FCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            toggle_f <= 1'b0;
        end else begin
            toggle_f <= toggle_s;
        end
    end

    // Right after an SCLK edge the FCLK copy still holds the old toggle value,
    // so the two differ in the first half of the SCLK cycle. They agree in
    // the second half, which is the FCLK cycle ending on the next SCLK edge.
    assign EDGE_OUT = started_s & (toggle_s == toggle_f);

endmodule

// File: rtl/spio_link_speed_doubler.sv
// rtl/spio_link_speed_doubler.sv - moves rdy/vld packets from the SCLK producer to a 2x FCLK consumer
//
// Configuration macro: SPIO_LINK_SPEED_DOUBLER_SKID_EN (adds the skid entry, DEPTH=2)
//
// Ports:
//   SCLK_IN   in   slow clock, producer handshake is taken on its rising edge
//   FCLK_IN   in   fast clock (2x SCLK_IN, aligned), clocks all storage
//   RESET_IN  in   asynchronous, active-high reset
//   DATA_IN   in   packet from producer
//   VLD_IN    in   producer valid
//   RDY_OUT   out  ready to producer, only updated on SCLK-coincident FCLK edges
//   DATA_OUT  out  packet to consumer
//   VLD_OUT   out  consumer valid
//   RDY_IN    in   consumer ready

module spio_link_speed_doubler
    import spio_link_speed_doubler_pkg::*;
#(
    parameter int PKT_BITS = 72
) (
    input  logic                SCLK_IN,
    input  logic                FCLK_IN,
    input  logic                RESET_IN,
    input  logic [PKT_BITS-1:0] DATA_IN,
    input  logic                VLD_IN,
    output logic                RDY_OUT,
    output logic [PKT_BITS-1:0] DATA_OUT,
    output logic                VLD_OUT,
    input  logic                RDY_IN
);

    logic                edge_i;
    logic                push;
    logic                pop;

    logic                out_vld_q;
    logic                out_vld_d;
    logic [PKT_BITS-1:0] out_data_q;
    logic [PKT_BITS-1:0] out_data_d;
    logic                rdy_q;
    logic                rdy_d;
    occ_t                occ_next;

    spio_sclk_edge_detect u_edge (
        .SCLK_IN  (SCLK_IN),
        .FCLK_IN  (FCLK_IN),
        .RESET_IN (RESET_IN),
        .EDGE_OUT (edge_i)
    );

    // The producer only moves on SCLK edges, so its handshake is honoured
    // only at the FCLK edge that coincides with one.
    assign push = edge_i & VLD_IN & rdy_q;
    assign pop  = out_vld_q & RDY_IN;

`ifdef SPIO_LINK_SPEED_DOUBLER_SKID_EN

    logic                skid_vld_q;
    logic                skid_vld_d;
    logic [PKT_BITS-1:0] skid_data_q;
    logic [PKT_BITS-1:0] skid_data_d;

    always_comb begin
        out_vld_d   = out_vld_q;
        out_data_d  = out_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;

        // Pop first: refill the output from the skid entry in the same edge.
        if (pop) begin
            if (skid_vld_q) begin
                out_data_d = skid_data_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = 1'b0;
            end
        end

        // A push lands in the output register if it is (or is becoming) free,
        // otherwise in the skid entry. RDY_OUT guarantees one of them is free.
        if (push) begin
            if (!out_vld_d) begin
                out_vld_d  = 1'b1;
                out_data_d = DATA_IN;
            end else begin
                skid_vld_d  = 1'b1;
                skid_data_d = DATA_IN;
            end
        end
    end

    always_ff @(posedge FCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
        end else begin
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign occ_next = occ_count(out_vld_d, skid_vld_d);

`else

    // Single-entry buffer: a push only happens when the output register was
    // empty at the previous SCLK edge, so it always loads the output.
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        if (pop) begin
            out_vld_d = 1'b0;
        end
        if (push) begin
            out_vld_d  = 1'b1;
            out_data_d = DATA_IN;
        end
    end

    assign occ_next = occ_count(out_vld_d, 1'b0);

`endif

    // Ready is recomputed only on SCLK-coincident edges; a pop on the
    // mid-cycle edge is picked up at the next SCLK edge.
    always_comb begin
        rdy_d = rdy_q;
        if (edge_i) begin
            rdy_d = (occ_next < DEPTH_OCC);
        end
    end

    always_ff @(posedge FCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            rdy_q      <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            rdy_q      <= rdy_d;
        end
    end

    assign RDY_OUT  = rdy_q;
    assign VLD_OUT  = out_vld_q;
    assign DATA_OUT = out_data_q;

endmodule

// File: tb/tb_spio_link_speed_doubler.sv
// tb/tb_spio_link_speed_doubler.sv - directed self-checking bench for spio_link_speed_doubler

module tb_spio_link_speed_doubler;

    logic        sclk;
    logic        fclk;
    logic        rst;
    logic [71:0] data_in;
    logic        vld_in;
    logic        rdy_out;
    logic [71:0] data_out;
    logic        vld_out;
    logic        rdy_in;

    int          n_cmp;
    int          n_bad;
    int          sclk_cnt;
    int          vld_hi_cnt;
    logic [71:0] rxq[$];
    time         rxt[$];

`ifdef SPIO_LINK_SPEED_DOUBLER_SKID_EN
    localparam int PUSH_GAP = 1;
`else
    localparam int PUSH_GAP = 2;
`endif

    spio_link_speed_doubler #(.PKT_BITS(72)) dut (
        .SCLK_IN  (sclk),
        .FCLK_IN  (fclk),
        .RESET_IN (rst),
        .DATA_IN  (data_in),
        .VLD_IN   (vld_in),
        .RDY_OUT  (rdy_out),
        .DATA_OUT (data_out),
        .VLD_OUT  (vld_out),
        .RDY_IN   (rdy_in)
    );

    initial begin
        fclk = 1'b0;
        forever #5 fclk = ~fclk;
    end

    initial begin
        sclk = 1'b0;
        #5;
        forever begin
            sclk = 1'b1;
            #10;
            sclk = 1'b0;
            #10;
        end
    end

    always @(posedge sclk) sclk_cnt++;

    always @(negedge fclk) begin
        if (vld_out === 1'b1) vld_hi_cnt++;
        if (vld_out === 1'b1 && rdy_in === 1'b1) begin
            rxq.push_back(data_out);
            rxt.push_back($time);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_sclk;
        @(posedge sclk);
        #1;
    endtask

    task automatic send(input logic [71:0] d, output int push_cyc);
        int budget;
        data_in = d;
        vld_in  = 1'b1;
        budget  = 0;
        while (rdy_out !== 1'b1 && budget < 50) begin
            wait_sclk;
            budget++;
        end
        n_cmp++;
        if (budget >= 50) begin
            n_bad++;
            $display("FAIL send_timeout: rdy_out=%b required 1", rdy_out);
        end
        wait_sclk;
        push_cyc = sclk_cnt;
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        vld_in  = 1'b0;
        data_in = '0;
        rdy_in  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_sclk;
            n_cmp++;
            if ({rdy_out, vld_out} !== 2'b00) begin
                n_bad++;
                $display("FAIL reset_hold: rdy/vld=%b%b required 00", rdy_out, vld_out);
            end
            n_cmp++;
            if (data_out !== 72'h0) begin
                n_bad++;
                $display("FAIL reset_data: data_out=%h required 0", data_out);
            end
        end
        rst = 1'b0;
        wait_sclk;
        n_cmp++;
        if (rdy_out !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_first_edge_rdy: rdy_out=%b required 0", rdy_out);
        end
        wait_sclk;
        n_cmp++;
        if (rdy_out !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_second_edge_rdy: rdy_out=%b required 1", rdy_out);
        end
    endtask

    task automatic test_streaming;
        int pc;
        int prev_pc;
        int cnt0;
        prev_pc = 0;
        rdy_in  = 1'b1;
        rxq.delete();
        rxt.delete();
        cnt0 = vld_hi_cnt;
        for (int i = 1; i <= 16; i++) begin
            send(72'(i), pc);
            n_cmp++;
            if ({vld_out, data_out} !== {1'b1, 72'(i)}) begin
                n_bad++;
                $display("FAIL stream_latency[%0d]: vld=%b data=%h required vld=1 data=%h",
                         i, vld_out, data_out, 72'(i));
            end
            if (i > 1) begin
                n_cmp++;
                if (pc - prev_pc !== PUSH_GAP) begin
                    n_bad++;
                    $display("FAIL stream_gap[%0d]: gap=%0d required %0d", i, pc - prev_pc, PUSH_GAP);
                end
            end
            prev_pc = pc;
            n_cmp++;
`ifdef SPIO_LINK_SPEED_DOUBLER_SKID_EN
            if (rdy_out !== 1'b1) begin
                n_bad++;
                $display("FAIL stream_rdy[%0d]: rdy_out=%b required 1", i, rdy_out);
            end
`else
            if (rdy_out !== 1'b0) begin
                n_bad++;
                $display("FAIL stream_rdy[%0d]: rdy_out=%b required 0", i, rdy_out);
            end
`endif
        end
        vld_in = 1'b0;
        repeat (3) wait_sclk;
        n_cmp++;
        if (rxq.size() !== 16) begin
            n_bad++;
            $display("FAIL stream_count: received=%0d required 16", rxq.size());
        end
        for (int i = 0; i < 16 && i < rxq.size(); i++) begin
            n_cmp++;
            if (rxq[i] !== 72'(i + 1)) begin
                n_bad++;
                $display("FAIL stream_order[%0d]: got=%h required %h", i, rxq[i], 72'(i + 1));
            end
        end
        n_cmp++;
        if (vld_hi_cnt - cnt0 !== 16) begin
            n_bad++;
            $display("FAIL stream_vld_pulses: count=%0d required 16", vld_hi_cnt - cnt0);
        end
    endtask

    task automatic test_stall;
        int pc;
        rdy_in = 1'b0;
        rxq.delete();
        rxt.delete();
        send(72'hA1, pc);
        n_cmp++;
        if ({vld_out, data_out} !== {1'b1, 72'hA1}) begin
            n_bad++;
            $display("FAIL stall_first: vld=%b data=%h required vld=1 data=a1", vld_out, data_out);
        end
`ifdef SPIO_LINK_SPEED_DOUBLER_SKID_EN
        n_cmp++;
        if (rdy_out !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_rdy_occ1: rdy_out=%b required 1", rdy_out);
        end
        send(72'hA2, pc);
`endif
        vld_in = 1'b0;
        n_cmp++;
        if (rdy_out !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_rdy_full: rdy_out=%b required 0", rdy_out);
        end
        repeat (2) wait_sclk;
        n_cmp++;
        if ({rdy_out, vld_out, data_out} !== {1'b0, 1'b1, 72'hA1}) begin
            n_bad++;
            $display("FAIL stall_hold: rdy=%b vld=%b data=%h required rdy=0 vld=1 data=a1",
                     rdy_out, vld_out, data_out);
        end
        rdy_in = 1'b1;
        #10;
        n_cmp++;
        if (rdy_out !== 1'b0) begin
            n_bad++;
            $display("FAIL midpop_rdy: rdy_out=%b required 0", rdy_out);
        end
`ifdef SPIO_LINK_SPEED_DOUBLER_SKID_EN
        n_cmp++;
        if ({vld_out, data_out} !== {1'b1, 72'hA2}) begin
            n_bad++;
            $display("FAIL midpop_skid_shift: vld=%b data=%h required vld=1 data=a2", vld_out, data_out);
        end
`else
        n_cmp++;
        if (vld_out !== 1'b0) begin
            n_bad++;
            $display("FAIL midpop_empty: vld_out=%b required 0", vld_out);
        end
`endif
        wait_sclk;
        n_cmp++;
        if (rdy_out !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release_rdy: rdy_out=%b required 1", rdy_out);
        end
`ifndef SPIO_LINK_SPEED_DOUBLER_SKID_EN
        send(72'hA2, pc);
        vld_in = 1'b0;
`endif
        wait_sclk;
        n_cmp++;
        if (vld_out !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_drained: vld_out=%b required 0", vld_out);
        end
        n_cmp++;
        if (rxq.size() !== 2) begin
            n_bad++;
            $display("FAIL stall_count: received=%0d required 2", rxq.size());
        end
        n_cmp++;
        if (rxq[0] !== 72'hA1 || rxq[1] !== 72'hA2) begin
            n_bad++;
            $display("FAIL stall_order: got=%h,%h required a1,a2", rxq[0], rxq[1]);
        end
`ifdef SPIO_LINK_SPEED_DOUBLER_SKID_EN
        n_cmp++;
        if (rxt[1] - rxt[0] !== 10) begin
            n_bad++;
            $display("FAIL stall_consecutive: spacing=%0t required 10", rxt[1] - rxt[0]);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int pc;
        rdy_in = 1'b0;
        rxq.delete();
        rxt.delete();
        send(72'hB1, pc);
`ifdef SPIO_LINK_SPEED_DOUBLER_SKID_EN
        send(72'hB2, pc);
`endif
        vld_in = 1'b0;
        n_cmp++;
        if ({rdy_out, vld_out} !== 2'b01) begin
            n_bad++;
            $display("FAIL rstmid_full: rdy/vld=%b%b required 01", rdy_out, vld_out);
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({rdy_out, vld_out, data_out} !== {2'b00, 72'h0}) begin
            n_bad++;
            $display("FAIL rstmid_immediate: rdy=%b vld=%b data=%h required rdy=0 vld=0 data=0",
                     rdy_out, vld_out, data_out);
        end
        wait_sclk;
        rst    = 1'b0;
        rdy_in = 1'b1;
        repeat (2) wait_sclk;
        n_cmp++;
        if (rdy_out !== 1'b1) begin
            n_bad++;
            $display("FAIL rstmid_recover_rdy: rdy_out=%b required 1", rdy_out);
        end
        repeat (2) wait_sclk;
        n_cmp++;
        if (rxq.size() !== 0 || vld_out !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_dropped: received=%0d vld=%b required 0 and 0", rxq.size(), vld_out);
        end
        send(72'hC1, pc);
        vld_in = 1'b0;
        repeat (2) wait_sclk;
        n_cmp++;
        if (rxq.size() !== 1 || rxq[0] !== 72'hC1) begin
            n_bad++;
            $display("FAIL rstmid_after: received=%0d first=%h required 1 and c1", rxq.size(), rxq[0]);
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        sclk_cnt   = 0;
        vld_hi_cnt = 0;
        rst        = 1'b1;
        vld_in     = 1'b0;
        data_in    = '0;
        rdy_in     = 1'b0;
        test_reset;
        test_streaming;
        test_stall;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
